// File: rtl/core_ma.sv
// Memory-access stage: consumes the EX/MEM entry, runs the data-bus load/store
// and presents the MEM/WB register, including the pending-load flag used by the bypass.
module core_ma #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        em_valid,
    output logic        em_ready,
    input  logic [31:0] em_reg_data_mem_addr,
    input  logic [31:0] em_csr_data_mem_data,
    input  logic        em_mem_read,
    input  logic        em_mem_write,
    input  logic [2:0]  em_mem_op_type,
    input  logic [4:0]  em_rd,
    input  logic        em_reg_write,
    input  logic [11:0] em_csr,
    input  logic        em_csr_write,
    output logic        bus_req,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        mw_valid,
    input  logic        mw_ready,
    output logic [4:0]  mw_rd,
    output logic        mw_reg_write,
    output logic [31:0] mw_reg_write_data,
    output logic        mw_mem_data_valid,
    output logic [11:0] mw_csr,
    output logic        mw_csr_write,
    output logic [31:0] mw_csr_data,
    output logic        ma_exc_valid,
    output logic [31:0] ma_exc_cause,
    output logic [31:0] ma_exc_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [2:0]  op_q, op_d;
    logic        load_q, load_d;
    logic        mw_valid_q, mw_valid_d, mw_reg_write_q, mw_reg_write_d;
    logic        mw_mdv_q, mw_mdv_d, mw_csr_write_q, mw_csr_write_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic [31:0] mw_wdata_q, mw_wdata_d, mw_csr_data_q, mw_csr_data_d;
    logic [11:0] mw_csr_q, mw_csr_d;
    logic        exc_valid_q, exc_valid_d;
    logic [31:0] exc_cause_q, exc_cause_d, exc_addr_q, exc_addr_d;
    logic        fire, is_mem, misalign;

    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] op);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (op[1:0])
            2'b00:   load_ext = op[2] ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'b01:   load_ext = op[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: load_ext = s;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] off, input logic [2:0] op);
        case (op[1:0])
            2'b00:   lane_strb = 4'b0001 << off;
            2'b01:   lane_strb = 4'b0011 << {off[1], 1'b0};
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [2:0] op);
        case (op[1:0])
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [2:0] op);
        case (op[1:0])
            2'b00:   align_addr = a;
            2'b01:   align_addr = {a[31:1], 1'b0};
            default: align_addr = {a[31:2], 2'b00};
        endcase
    endfunction

    assign em_ready = (state_q == IDLE) && (!mw_valid_q || mw_ready);
    assign fire     = em_valid && em_ready;
    assign is_mem   = em_mem_read || em_mem_write;
    assign misalign = ((em_mem_op_type[1:0] == 2'b01) && em_reg_data_mem_addr[0]) ||
                      (em_mem_op_type[1] && (em_reg_data_mem_addr[1:0] != 2'b00));

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        op_d           = op_q;
        load_d         = load_q;
        mw_valid_d     = mw_valid_q && !mw_ready;
        mw_rd_d        = mw_rd_q;
        mw_reg_write_d = mw_reg_write_q;
        mw_wdata_d     = mw_wdata_q;
        mw_mdv_d       = mw_mdv_q;
        mw_csr_d       = mw_csr_q;
        mw_csr_write_d = mw_csr_write_q;
        mw_csr_data_d  = mw_csr_data_q;
        exc_valid_d    = 1'b0;
        exc_cause_d    = exc_cause_q;
        exc_addr_d     = exc_addr_q;
        case (state_q)
            IDLE: begin
                if (fire && !is_mem) begin
                    mw_valid_d     = 1'b1;
                    mw_rd_d        = em_rd;
                    mw_reg_write_d = em_reg_write;
                    mw_wdata_d     = em_reg_data_mem_addr;
                    mw_mdv_d       = 1'b1;
                    mw_csr_d       = em_csr;
                    mw_csr_write_d = em_csr_write;
                    mw_csr_data_d  = em_csr_data_mem_data;
                end else if (fire && misalign && MISALIGN_CHECK) begin
                    mw_valid_d     = 1'b1;
                    mw_rd_d        = em_rd;
                    mw_reg_write_d = 1'b0;
                    mw_csr_write_d = 1'b0;
                    mw_mdv_d       = 1'b1;
                    exc_valid_d    = 1'b1;
                    exc_cause_d    = em_mem_read ? 32'd4 : 32'd6;
                    exc_addr_d     = em_reg_data_mem_addr;
                end else if (fire) begin
                    addr_d  = align_addr(em_reg_data_mem_addr, em_mem_op_type);
                    data_d  = em_csr_data_mem_data;
                    op_d    = em_mem_op_type;
                    load_d  = em_mem_read;
                    state_d = REQ;
                    // Publish the load's destination now so the bypass sees the hazard.
                    if (em_mem_read) begin
                        mw_rd_d        = em_rd;
                        mw_reg_write_d = em_reg_write;
                        mw_csr_d       = em_csr;
                        mw_csr_write_d = 1'b0;
                        mw_mdv_d       = 1'b0;
                    end
                end
            end
            REQ: begin
                if (bus_ready && load_q) begin
                    state_d = WAIT_RD;
                end else if (bus_ready) begin
                    state_d        = IDLE;
                    mw_valid_d     = 1'b1;
                    mw_reg_write_d = 1'b0;
                    mw_csr_write_d = 1'b0;
                    mw_mdv_d       = 1'b1;
                end
            end
            WAIT_RD: begin
                if (bus_rvalid) begin
                    state_d    = IDLE;
                    mw_valid_d = 1'b1;
                    mw_wdata_d = load_ext(bus_rdata, addr_q[1:0], op_q);
                    mw_mdv_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            op_q           <= '0;
            load_q         <= 1'b0;
            mw_valid_q     <= 1'b0;
            mw_rd_q        <= '0;
            mw_reg_write_q <= 1'b0;
            mw_wdata_q     <= '0;
            mw_mdv_q       <= 1'b1;
            mw_csr_q       <= '0;
            mw_csr_write_q <= 1'b0;
            mw_csr_data_q  <= '0;
            exc_valid_q    <= 1'b0;
            exc_cause_q    <= '0;
            exc_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            op_q           <= op_d;
            load_q         <= load_d;
            mw_valid_q     <= mw_valid_d;
            mw_rd_q        <= mw_rd_d;
            mw_reg_write_q <= mw_reg_write_d;
            mw_wdata_q     <= mw_wdata_d;
            mw_mdv_q       <= mw_mdv_d;
            mw_csr_q       <= mw_csr_d;
            mw_csr_write_q <= mw_csr_write_d;
            mw_csr_data_q  <= mw_csr_data_d;
            exc_valid_q    <= exc_valid_d;
            exc_cause_q    <= exc_cause_d;
            exc_addr_q     <= exc_addr_d;
        end
    end

    // Bus outputs are decoded from the latched request and read as zero outside REQ.
    assign bus_req   = (state_q == REQ);
    assign bus_write = bus_req && !load_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wstrb = bus_req ? lane_strb(addr_q[1:0], op_q) : 4'h0;
    assign bus_wdata = bus_req ? lane_data(data_q, op_q) : 32'h0;

    assign mw_valid          = mw_valid_q;
    assign mw_rd             = mw_rd_q;
    assign mw_reg_write      = mw_reg_write_q;
    assign mw_reg_write_data = mw_wdata_q;
    assign mw_mem_data_valid = mw_mdv_q;
    assign mw_csr            = mw_csr_q;
    assign mw_csr_write      = mw_csr_write_q;
    assign mw_csr_data       = mw_csr_data_q;
    assign ma_exc_valid      = exc_valid_q;
    assign ma_exc_cause      = exc_cause_q;
    assign ma_exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_core_ma.sv
// Directed bench for core_ma: ALU pass-through, stores, loads, misalignment,
// writeback back-pressure and reset during an outstanding read.
module tb_core_ma;

    logic        clk, rest;
    logic        em_valid, em_ready;
    logic [31:0] em_reg_data_mem_addr, em_csr_data_mem_data;
    logic        em_mem_read, em_mem_write;
    logic [2:0]  em_mem_op_type;
    logic [4:0]  em_rd;
    logic        em_reg_write;
    logic [11:0] em_csr;
    logic        em_csr_write;
    logic        bus_req, bus_ready, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        mw_valid, mw_ready;
    logic [4:0]  mw_rd;
    logic        mw_reg_write;
    logic [31:0] mw_reg_write_data;
    logic        mw_mem_data_valid;
    logic [11:0] mw_csr;
    logic        mw_csr_write;
    logic [31:0] mw_csr_data;
    logic        ma_exc_valid;
    logic [31:0] ma_exc_cause, ma_exc_addr;

    int n_cmp = 0;
    int n_err = 0;

    core_ma #(.MISALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rest(rest),
        .em_valid(em_valid), .em_ready(em_ready),
        .em_reg_data_mem_addr(em_reg_data_mem_addr), .em_csr_data_mem_data(em_csr_data_mem_data),
        .em_mem_read(em_mem_read), .em_mem_write(em_mem_write), .em_mem_op_type(em_mem_op_type),
        .em_rd(em_rd), .em_reg_write(em_reg_write), .em_csr(em_csr), .em_csr_write(em_csr_write),
        .bus_req(bus_req), .bus_ready(bus_ready), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .mw_valid(mw_valid), .mw_ready(mw_ready), .mw_rd(mw_rd), .mw_reg_write(mw_reg_write),
        .mw_reg_write_data(mw_reg_write_data), .mw_mem_data_valid(mw_mem_data_valid),
        .mw_csr(mw_csr), .mw_csr_write(mw_csr_write), .mw_csr_data(mw_csr_data),
        .ma_exc_valid(ma_exc_valid), .ma_exc_cause(ma_exc_cause), .ma_exc_addr(ma_exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic em_clear;
        em_valid = 0; em_mem_read = 0; em_mem_write = 0; em_mem_op_type = 3'b000;
        em_reg_data_mem_addr = 0; em_csr_data_mem_data = 0; em_rd = 0;
        em_reg_write = 0; em_csr = 0; em_csr_write = 0;
    endtask

    task automatic test_reset;
        rest = 1; tick(); tick(); rest = 0;
        n_cmp++;
        if ({em_ready, mw_mem_data_valid, mw_valid, bus_req, ma_exc_valid, mw_reg_write} !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 110000",
                     {em_ready, mw_mem_data_valid, mw_valid, bus_req, ma_exc_valid, mw_reg_write});
        end
        n_cmp++;
        if ({mw_reg_write_data, mw_rd, bus_addr, ma_exc_cause} !== '0) begin
            n_err++;
            $display("FAIL reset_data got %h exp 0", {mw_reg_write_data, mw_rd, bus_addr, ma_exc_cause});
        end
    endtask

    task automatic test_alu;
        em_valid = 1; em_reg_data_mem_addr = 32'h1234; em_rd = 5; em_reg_write = 1;
        em_csr_data_mem_data = 32'hC0DE; em_csr = 12'h305; em_csr_write = 1;
        tick(); em_clear();
        n_cmp++;
        if ({mw_valid, mw_rd, mw_reg_write, mw_reg_write_data, mw_mem_data_valid} !== {1'b1, 5'd5, 1'b1, 32'h1234, 1'b1}) begin
            n_err++;
            $display("FAIL alu_result got v=%b rd=%0d we=%b d=%h mdv=%b exp v=1 rd=5 we=1 d=00001234 mdv=1",
                     mw_valid, mw_rd, mw_reg_write, mw_reg_write_data, mw_mem_data_valid);
        end
        n_cmp++;
        if ({mw_csr, mw_csr_write, mw_csr_data} !== {12'h305, 1'b1, 32'hC0DE}) begin
            n_err++;
            $display("FAIL alu_csr got %h %b %h exp 305 1 0000c0de", mw_csr, mw_csr_write, mw_csr_data);
        end
        tick();
        n_cmp++;
        if (mw_valid !== 1'b0) begin
            n_err++;
            $display("FAIL alu_pulse got mw_valid=%b exp 0", mw_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            em_valid = 1; em_reg_data_mem_addr = vals[i]; em_rd = 5'(i + 1); em_reg_write = 1;
            #1;
            n_cmp++;
            if (em_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d] got %b exp 1", i, em_ready);
            end
            tick();
            n_cmp++;
            if ({mw_valid, mw_rd, mw_reg_write_data} !== {1'b1, 5'(i + 1), vals[i]}) begin
                n_err++;
                $display("FAIL b2b_result[%0d] got v=%b rd=%0d d=%h exp v=1 rd=%0d d=%h",
                         i, mw_valid, mw_rd, mw_reg_write_data, i + 1, vals[i]);
            end
        end
        em_clear();
        tick();
    endtask

    task automatic test_store_byte;
        em_valid = 1; em_mem_write = 1; em_mem_op_type = 3'b000;
        em_reg_data_mem_addr = 32'h1003; em_csr_data_mem_data = 32'h0000_00AB;
        bus_ready = 0;
        tick(); em_clear();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus_req, bus_write, bus_addr, bus_wstrb, bus_wdata, em_ready, mw_valid} !==
                {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hABABABAB, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL store_req[%0d] got req=%b wr=%b a=%h s=%b d=%h rdy=%b v=%b exp 1 1 00001000 1000 abababab 0 0",
                         i, bus_req, bus_write, bus_addr, bus_wstrb, bus_wdata, em_ready, mw_valid);
            end
            if (i == 2) bus_ready = 1;
            tick();
        end
        bus_ready = 0;
        n_cmp++;
        if ({bus_req, mw_valid, mw_reg_write, mw_mem_data_valid} !== 4'b0101) begin
            n_err++;
            $display("FAIL store_done got req=%b v=%b we=%b mdv=%b exp 0 1 0 1",
                     bus_req, mw_valid, mw_reg_write, mw_mem_data_valid);
        end
        tick();
    endtask

    task automatic test_loads;
        logic [31:0] addrs [4];
        logic [2:0]  ops   [4];
        logic [31:0] rdat  [4];
        logic [31:0] exps  [4];
        addrs[0] = 32'h2001; ops[0] = 3'b000; rdat[0] = 32'h0000_8000; exps[0] = 32'hFFFF_FF80;
        addrs[1] = 32'h2001; ops[1] = 3'b100; rdat[1] = 32'h0000_8000; exps[1] = 32'h0000_0080;
        addrs[2] = 32'h2002; ops[2] = 3'b001; rdat[2] = 32'h8001_0000; exps[2] = 32'hFFFF_8001;
        addrs[3] = 32'h2002; ops[3] = 3'b101; rdat[3] = 32'h8001_0000; exps[3] = 32'h0000_8001;
        for (int i = 0; i < 4; i++) begin
            em_valid = 1; em_mem_read = 1; em_mem_op_type = ops[i];
            em_reg_data_mem_addr = addrs[i]; em_rd = 7; em_reg_write = 1;
            tick(); em_clear();
            n_cmp++;
            if ({mw_mem_data_valid, mw_rd, mw_reg_write, mw_valid, bus_req, bus_write, bus_addr} !==
                {1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2000}) begin
                n_err++;
                $display("FAIL load_req[%0d] got mdv=%b rd=%0d we=%b v=%b req=%b wr=%b a=%h exp 0 7 1 0 1 0 00002000",
                         i, mw_mem_data_valid, mw_rd, mw_reg_write, mw_valid, bus_req, bus_write, bus_addr);
            end
            bus_ready = 1; tick(); bus_ready = 0;
            tick();
            n_cmp++;
            if ({bus_req, mw_mem_data_valid, mw_valid, em_ready} !== 4'b0000) begin
                n_err++;
                $display("FAIL load_wait[%0d] got req=%b mdv=%b v=%b rdy=%b exp 0 0 0 0",
                         i, bus_req, mw_mem_data_valid, mw_valid, em_ready);
            end
            bus_rvalid = 1; bus_rdata = rdat[i];
            tick();
            bus_rvalid = 0; bus_rdata = 0;
            n_cmp++;
            if ({mw_valid, mw_mem_data_valid, mw_reg_write_data} !== {1'b1, 1'b1, exps[i]}) begin
                n_err++;
                $display("FAIL load_data[%0d] got v=%b mdv=%b d=%h exp v=1 mdv=1 d=%h",
                         i, mw_valid, mw_mem_data_valid, mw_reg_write_data, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] addrs  [2];
        logic [2:0]  ops    [2];
        logic        is_ld  [2];
        logic [31:0] causes [2];
        addrs[0] = 32'h2005; ops[0] = 3'b010; is_ld[0] = 1; causes[0] = 32'd4;
        addrs[1] = 32'h3001; ops[1] = 3'b001; is_ld[1] = 0; causes[1] = 32'd6;
        for (int i = 0; i < 2; i++) begin
            em_valid = 1; em_mem_read = is_ld[i]; em_mem_write = !is_ld[i];
            em_mem_op_type = ops[i]; em_reg_data_mem_addr = addrs[i]; em_rd = 3; em_reg_write = 1;
            tick(); em_clear();
            n_cmp++;
            if ({ma_exc_valid, ma_exc_cause, ma_exc_addr, mw_valid, mw_reg_write, mw_csr_write, bus_req, em_ready} !==
                {1'b1, causes[i], addrs[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL misalign[%0d] got exc=%b c=%0d a=%h v=%b we=%b cw=%b req=%b rdy=%b exp 1 %0d %h 1 0 0 0 1",
                         i, ma_exc_valid, ma_exc_cause, ma_exc_addr, mw_valid, mw_reg_write,
                         mw_csr_write, bus_req, em_ready, causes[i], addrs[i]);
            end
            tick();
            n_cmp++;
            if ({ma_exc_valid, bus_req, mw_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL misalign_after[%0d] got exc=%b req=%b v=%b exp 0 0 0",
                         i, ma_exc_valid, bus_req, mw_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        mw_ready = 0;
        em_valid = 1; em_reg_data_mem_addr = 32'h55; em_rd = 9; em_reg_write = 1;
        tick();
        em_reg_data_mem_addr = 32'h66; em_rd = 10;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({mw_valid, mw_rd, mw_reg_write_data, em_ready} !== {1'b1, 5'd9, 32'h55, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got v=%b rd=%0d d=%h rdy=%b exp 1 9 00000055 0",
                         i, mw_valid, mw_rd, mw_reg_write_data, em_ready);
            end
            tick();
        end
        mw_ready = 1;
        #1;
        n_cmp++;
        if (em_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got em_ready=%b exp 1", em_ready);
        end
        tick(); em_clear();
        n_cmp++;
        if ({mw_valid, mw_rd, mw_reg_write_data} !== {1'b1, 5'd10, 32'h66}) begin
            n_err++;
            $display("FAIL bp_next got v=%b rd=%0d d=%h exp 1 10 00000066", mw_valid, mw_rd, mw_reg_write_data);
        end
        tick();
    endtask

    task automatic test_reset_wait_rd;
        em_valid = 1; em_mem_read = 1; em_mem_op_type = 3'b010;
        em_reg_data_mem_addr = 32'h2000; em_rd = 12; em_reg_write = 1;
        tick(); em_clear();
        bus_ready = 1; tick(); bus_ready = 0;
        n_cmp++;
        if ({bus_req, mw_mem_data_valid, em_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_pre got req=%b mdv=%b rdy=%b exp 0 0 0", bus_req, mw_mem_data_valid, em_ready);
        end
        rest = 1; tick(); rest = 0;
        n_cmp++;
        if ({em_ready, mw_mem_data_valid, mw_valid, mw_reg_write, mw_rd, bus_req} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid got rdy=%b mdv=%b v=%b we=%b rd=%0d req=%b exp 1 1 0 0 0 0",
                     em_ready, mw_mem_data_valid, mw_valid, mw_reg_write, mw_rd, bus_req);
        end
        bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_rvalid = 0; bus_rdata = 0;
        n_cmp++;
        if ({mw_valid, mw_reg_write_data, mw_mem_data_valid, em_ready} !== {1'b0, 32'h0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL rst_stray got v=%b d=%h mdv=%b rdy=%b exp 0 00000000 1 1",
                     mw_valid, mw_reg_write_data, mw_mem_data_valid, em_ready);
        end
    endtask

    initial begin
        em_clear();
        rest = 1; mw_ready = 1; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_store_byte();
        test_loads();
        test_misaligned();
        test_backpressure();
        test_reset_wait_rd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
